// File: rtl/rri_pkg.sv
// Shared definitions for the RRI pulse generator slice.
//   - default datapath widths and the minimum legal period
//   - FSM state encoding
//   - calc_w_eff(): clamps a requested pulse width into [1, p_eff-1]
package rri_pkg;

  localparam int DEF_CNT_W      = 32;
  localparam int DEF_WID_W      = 16;
  localparam int DEF_MIN_PERIOD = 2;

  typedef logic [DEF_CNT_W-1:0] cnt_t;
  typedef logic [DEF_WID_W-1:0] wid_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EPOCH,
    HIGH,
    LOW,
    DONE
  } state_e;

  // Effective high time: at least one clock, and always leaves at least one
  // low clock inside the period so consecutive pulses stay distinguishable.
  // p_eff is already >= MIN_PERIOD (>= 2), so p_eff-1 never underflows.
  function automatic cnt_t calc_w_eff(input wid_t width, input cnt_t p_eff);
    cnt_t w;
    w = cnt_t'(width);
    if (w == '0) w = cnt_t'(1);
    if (w > p_eff - cnt_t'(1)) w = p_eff - cnt_t'(1);
    return w;
  endfunction

endpackage

// File: rtl/rri_pulse_gen_if.sv
// Control/status bundle of the pulse generator.
//   start, stop             : one-cycle strobes from the controller
//   period, epoch, width,
//   num_pulses              : run configuration, sampled on start
//   pulse_out               : registered pulse train
//   pulse_cnt, phase        : pulse index and clocks since last rise
//   busy, done              : run status
// master = controller side, slave = generator side.
interface rri_pulse_gen_if
  import rri_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WID_W = DEF_WID_W
);

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] epoch;
  logic [WID_W-1:0] width;
  logic [CNT_W-1:0] num_pulses;
  logic             pulse_out;
  logic [CNT_W-1:0] pulse_cnt;
  logic [CNT_W-1:0] phase;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, period, epoch, width, num_pulses,
    input  pulse_out, pulse_cnt, phase, busy, done
  );

  modport slave (
    input  start, stop, period, epoch, width, num_pulses,
    output pulse_out, pulse_cnt, phase, busy, done
  );

endinterface

// File: rtl/rri_interval_cnt.sv
// Loadable down-counter with terminal-count flag.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : load load_val this cycle (has priority over counting)
//   load_val  : interval length minus one
//   tc        : count is zero (last cycle of the interval)
// A load of N gives an interval of N+1 cycles ending with tc=1.
module rri_interval_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/rri_pulse_gen.sv
// Periodic pulse-train generator (transmit side of the RRI folding input).
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : rri_pulse_gen_if.slave (config, strobes, pulse and status)
// On start (in IDLE, without stop) the configuration is latched; the first
// rise follows epoch+1 clocks later, then pulses repeat every p_eff clocks,
// each high for w_eff clocks, until num_pulses are sent (0 = forever) or
// stop aborts the run.
module rri_pulse_gen
  import rri_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WID_W      = DEF_WID_W,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic           clk,
  input  logic           rst,
  rri_pulse_gen_if.slave bus
);

  state_e           state_q, state_d;

  // Latched run configuration
  logic [CNT_W-1:0] p_eff_q;
  logic [CNT_W-1:0] w_eff_q;
  logic [CNT_W-1:0] num_q;

  logic [CNT_W-1:0] pulse_cnt_q;
  logic [CNT_W-1:0] phase_q;
  logic             pulse_out_q;

  logic [WID_W-1:0] width_in;
  logic [CNT_W-1:0] p_eff_in;
  logic [CNT_W-1:0] w_eff_in;
  logic             latch;
  logic             rise;
  logic             last_pulse;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_tc;

  assign width_in = bus.width;
  assign p_eff_in = (bus.period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : bus.period;
  assign w_eff_in = calc_w_eff(width_in, p_eff_in);

  // pulse_cnt already counts the pulse currently high, so equality with the
  // latched count marks the final pulse of a finite run.
  assign last_pulse = (num_q != '0) && (pulse_cnt_q == num_q);

  rri_interval_cnt #(.W(CNT_W)) u_interval (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tc       (cnt_tc)
  );

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    latch        = 1'b0;
    rise         = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          latch        = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = bus.epoch;
          state_d      = WAIT_EPOCH;
        end
      end

      WAIT_EPOCH: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_tc) begin
          rise         = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = w_eff_q - CNT_W'(1);
          state_d      = HIGH;
        end
      end

      HIGH: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_tc) begin
          if (last_pulse) begin
            // Finite run ends on the falling edge; the trailing gap is skipped.
            state_d = DONE;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = p_eff_q - w_eff_q - CNT_W'(1);
            state_d      = LOW;
          end
        end
      end

      LOW: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_tc) begin
          rise         = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = w_eff_q - CNT_W'(1);
          state_d      = HIGH;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      p_eff_q     <= '0;
      w_eff_q     <= '0;
      num_q       <= '0;
      pulse_cnt_q <= '0;
      phase_q     <= '0;
      pulse_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_out_q <= (state_d == HIGH);

      if (latch) begin
        p_eff_q     <= p_eff_in;
        w_eff_q     <= w_eff_in;
        num_q       <= bus.num_pulses;
        pulse_cnt_q <= '0;
        phase_q     <= '0;
      end else if (rise) begin
        pulse_cnt_q <= pulse_cnt_q + CNT_W'(1);
        phase_q     <= '0;
      end else if ((state_q == HIGH || state_q == LOW) &&
                   (state_d == HIGH || state_d == LOW)) begin
        // Advance only while the train keeps running; stop and run end freeze it.
        phase_q <= phase_q + CNT_W'(1);
      end
    end
  end

  assign bus.pulse_out = pulse_out_q;
  assign bus.pulse_cnt = pulse_cnt_q;
  assign bus.phase     = phase_q;
  assign bus.busy      = (state_q == WAIT_EPOCH) || (state_q == HIGH) || (state_q == LOW);
  assign bus.done      = (state_q == DONE);

endmodule
